// File: rtl/lfsr_seq_checker_pkg.sv
// Shared types and LFSR step/predict helpers for the 4-bit LFSR sequence checker.
package lfsr_chk_pkg;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam logic POLY_TAP_S2 = 1'b0;
  localparam logic POLY_TAP_S0 = 1'b1;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s, input logic poly_sel);
    logic fb;
    fb = (poly_sel == POLY_TAP_S0) ? (s[3] ^ s[0]) : (s[3] ^ s[2]);
    return {s[2:0], fb};
  endfunction

  // mode[2:1] holds the number of steps per sample minus one.
  function automatic logic [3:0] lfsr_predict(input logic [3:0] s, input logic [2:0] mode);
    logic [3:0] w;
    w = s;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) <= mode[2:1]) w = lfsr_step(w, mode[0]);
    end
    return w;
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Sample/status bundle between the looped-back LFSR source and the checker.
interface lfsr_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic             sample_valid;
  logic [3:0]       sample;
  logic [2:0]       mode;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             stuck;

  modport master (
    output sample_valid, sample, mode, clear_cnt,
    input  locked, err_pulse, err_count, stuck
  );

  modport slave (
    input  sample_valid, sample, mode, clear_cnt,
    output locked, err_pulse, err_count, stuck
  );
endinterface

// File: rtl/lfsr_seq_checker_predict.sv
// Combinational next-word predictor: applies the selected LFSR step 1..4 times.
module lfsr4_predict
  import lfsr_chk_pkg::*;
(
  input  logic [3:0] sample,
  input  logic [2:0] mode,
  output logic [3:0] pred
);
  assign pred = lfsr_predict(sample, mode);
endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 4-bit LFSR pattern; flywheel tracking once locked.
// Optional all-zero lockup detector enabled by defining LFSR_CHK_STUCK_EN.
//
// state  | meaning
// SEEK   | hunting: counting consecutive correct predictions from the previous sample
// LOCKED | tracking: comparing samples against the free-running expected word
module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int LOCK_MATCHES  = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  lfsr_seq_checker_if.slave  bus
);

  localparam int MW  = $clog2(LOCK_MATCHES + 1);
  localparam int MSW = $clog2(UNLOCK_MISSES + 1);

  chk_state_e       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MSW-1:0]   miss_q, miss_d;
  logic [3:0]       expected_q, expected_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             cnt_inc;
  logic             accept;
  logic             seek_hit;
  logic             lock_hit;
  logic [3:0]       pred_prev;
  logic [3:0]       pred_aux;
  logic [3:0]       aux_in;

  // aux path: in SEEK it yields pred(sample) for seeding the flywheel, in LOCKED pred(expected).
  assign aux_in = (state_q == SEEK) ? bus.sample : expected_q;

  lfsr4_predict u_pred_prev (
    .sample (prev_q),
    .mode   (mode_q),
    .pred   (pred_prev)
  );

  lfsr4_predict u_pred_aux (
    .sample (aux_in),
    .mode   (mode_q),
    .pred   (pred_aux)
  );

  assign accept   = ena && (bus.mode == mode_q) && bus.sample_valid;
  assign seek_hit = have_prev_q && (bus.sample == pred_prev) && (bus.sample != 4'd0);
  assign lock_hit = (bus.sample == expected_q) && (bus.sample != 4'd0);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    cnt_inc     = 1'b0;

    if (ena) begin
      if (bus.mode != mode_q) begin
        mode_d      = bus.mode;
        state_d     = SEEK;
        have_prev_d = 1'b0;
        match_d     = '0;
        miss_d      = '0;
      end else if (bus.sample_valid) begin
        case (state_q)
          SEEK: begin
            prev_d      = bus.sample;
            have_prev_d = 1'b1;
            if (!seek_hit) begin
              match_d = '0;
            end else if (match_q == MW'(LOCK_MATCHES - 1)) begin
              state_d    = LOCKED;
              expected_d = pred_aux;
              match_d    = '0;
              miss_d     = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end
          LOCKED: begin
            expected_d = pred_aux;
            if (lock_hit) begin
              miss_d = '0;
            end else begin
              err_pulse_d = 1'b1;
              cnt_inc     = 1'b1;
              if (miss_q == MSW'(UNLOCK_MISSES - 1)) begin
                state_d     = SEEK;
                match_d     = '0;
                miss_d      = '0;
                prev_d      = bus.sample;
                have_prev_d = 1'b1;
              end else begin
                miss_d = miss_q + MSW'(1);
              end
            end
          end
          default: state_d = SEEK;
        endcase
      end

      if (bus.clear_cnt) err_count_d = '0;
      else if (cnt_inc && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEEK;
      mode_q      <= 3'd0;
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      expected_q  <= 4'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

`ifdef LFSR_CHK_STUCK_EN
  logic [3:0] zero_cnt_q, zero_cnt_d;
  logic       stuck_q, stuck_d;

  // Counts consecutive accepted all-zero words, saturating once the flag is raised.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    stuck_d    = stuck_q;
    if (accept) begin
      if (bus.sample == 4'd0) begin
        if (zero_cnt_q != 4'd8) zero_cnt_d = zero_cnt_q + 4'd1;
        if (zero_cnt_q >= 4'd7) stuck_d = 1'b1;
      end else begin
        zero_cnt_d = 4'd0;
        stuck_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= 4'd0;
      stuck_q    <= 1'b0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      stuck_q    <= stuck_d;
    end
  end

  assign bus.stuck = stuck_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.stuck     = 1'b0;
`endif

endmodule
